// File: rtl/io_pins_pkg.sv
// Shared definitions for the io_pins_fpga walking-pattern self-test.
// Holds the default pin count, the byte-array geometry, the sequencer state
// type and a helper that maps a pin index onto its byte/bit position.
package io_pins_pkg;

    localparam int unsigned PINS_CONT_DEF = 132;
    localparam int unsigned PIN_BYTES     = 17;
    localparam int unsigned PIN_IDX_W     = 8;

    typedef logic [PIN_BYTES-1:0][7:0] pin_bytes_t;

    typedef enum logic [2:0] {
        StIdle,
        StNext,
        StLoad,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } state_t;

    typedef struct packed {
        logic [4:0] byte_idx;
        logic [2:0] bit_idx;
    } pin_loc_t;

    // Pin i lives in byte i/8, bit i%8.
    function automatic pin_loc_t pin_to_byte_bit(input logic [PIN_IDX_W-1:0] idx);
        pin_loc_t loc;
        loc.byte_idx = idx[7:3];
        loc.bit_idx  = idx[2:0];
        return loc;
    endfunction

endpackage

// File: rtl/io_pins_walk_test_ctrl_pattern_gen.sv
// io_pins_pattern_gen: combinational walking-pattern generator.
// Ports:
//   idx        in   pin index currently under test
//   mode       in   0 = walking-one, 1 = walking-zero
//   pattern    out  pattern bytes for that index (invalid top bits are 0)
//   valid_mask out  1 for every bit that maps onto a real pin
module io_pins_pattern_gen
    import io_pins_pkg::*;
#(
    parameter int unsigned PINS_CONT = PINS_CONT_DEF
) (
    input  logic [PIN_IDX_W-1:0]      idx,
    input  logic                      mode,
    output logic [PIN_BYTES-1:0][7:0] pattern,
    output logic [PIN_BYTES-1:0][7:0] valid_mask
);

    localparam logic [PIN_BYTES*8-1:0] VALID_BITS =
        {{(PIN_BYTES*8-PINS_CONT){1'b0}}, {PINS_CONT{1'b1}}};

    pin_loc_t                  loc;
    logic [PIN_BYTES-1:0][7:0] one_hot;

    always_comb begin
        valid_mask = VALID_BITS;
        loc        = pin_to_byte_bit(idx);
        one_hot    = '0;
        if (idx < PIN_IDX_W'(PINS_CONT)) begin
            one_hot[loc.byte_idx][loc.bit_idx] = 1'b1;
        end
        // Walking-zero keeps the unused top bits of the last byte at 0.
        pattern = mode ? (~one_hot & valid_mask) : one_hot;
    end

endmodule

// File: rtl/io_pins_walk_test_ctrl.sv
// io_pins_walk_test_ctrl: walking-one / walking-zero self-test sequencer for
// the io_pins_fpga pin bank. Per unmasked pin it loads a pattern, drives it
// with write_enable, releases the bus, lets the bank settle, then compares the
// sampled input array against the pattern over all unmasked pins.
// Ports:
//   CLK50, RST             clock, asynchronous active-high reset
//   start, abort, mode     host control (mode latched on start accept)
//   pin_mask               1 = pin skipped and excluded from comparison
//   write_enable           drive strobe to io_pins_fpga (high only in DRIVE)
//   output_pins_state      pattern bytes to io_pins_fpga
//   input_pins_state       sampled bytes from io_pins_fpga
//   busy, done             run in progress / one-cycle completion pulse
//   fail_vec, fail_count   sticky per-step fail bits and failing-step count
//   first_fail             first failing step index, 8'hFF if none
module io_pins_walk_test_ctrl
    import io_pins_pkg::*;
#(
    parameter int unsigned PINS_CONT     = PINS_CONT_DEF,
    parameter int unsigned DRIVE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                      CLK50,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      mode,
    input  logic [PINS_CONT-1:0]      pin_mask,
    output logic                      write_enable,
    output logic [PIN_BYTES-1:0][7:0] output_pins_state,
    input  logic [PIN_BYTES-1:0][7:0] input_pins_state,
    output logic                      busy,
    output logic                      done,
    output logic [PINS_CONT-1:0]      fail_vec,
    output logic [7:0]                fail_count,
    output logic [7:0]                first_fail
);

    localparam int unsigned CNT_W = 4;
    localparam logic [PIN_IDX_W-1:0] LAST_IDX = PIN_IDX_W'(PINS_CONT);
    localparam logic [CNT_W-1:0] DRIVE_LAST  = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [PIN_IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      mode_q, mode_d;
    logic [PIN_BYTES-1:0][7:0] pattern_q, pattern_d;
    logic [PINS_CONT-1:0]      fail_vec_q, fail_vec_d;
    logic [7:0]                fail_count_q, fail_count_d;
    logic [7:0]                first_fail_q, first_fail_d;

    logic [PIN_BYTES-1:0][7:0] gen_pattern;
    logic [PIN_BYTES-1:0][7:0] gen_valid;
    logic [PIN_BYTES*8-1:0]    mask_flat;
    logic                      mismatch;

    // The same generator feeds LOAD and the CHECK compare; idx is stable
    // across a step so both see the identical pattern.
    io_pins_pattern_gen #(
        .PINS_CONT (PINS_CONT)
    ) u_pattern_gen (
        .idx        (idx_q),
        .mode       (mode_q),
        .pattern    (gen_pattern),
        .valid_mask (gen_valid)
    );

    assign mask_flat = {{(PIN_BYTES*8-PINS_CONT){1'b0}}, pin_mask};
    assign mismatch  = |((input_pins_state ^ gen_pattern) & gen_valid & ~mask_flat);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        pattern_d    = pattern_q;
        fail_vec_d   = fail_vec_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;

        if (abort) begin
            // Results keep their partial values; start in the same cycle is dropped.
            state_d   = StIdle;
            pattern_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        fail_vec_d   = '0;
                        fail_count_d = '0;
                        first_fail_d = 8'hFF;
                        mode_d       = mode;
                        idx_d        = '0;
                        state_d      = StNext;
                    end
                end
                StNext: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else if (mask_flat[idx_q]) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    pattern_d = gen_pattern;
                    cnt_d     = '0;
                    state_d   = StDrive;
                end
                StDrive: begin
                    if (cnt_q == DRIVE_LAST) begin
                        cnt_d   = '0;
                        state_d = StSettle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        fail_vec_d[idx_q] = 1'b1;
                        fail_count_d      = fail_count_q + 8'd1;
                        if (first_fail_q == 8'hFF) begin
                            first_fail_d = idx_q;
                        end
                    end
                    idx_d   = idx_q + 1'b1;
                    state_d = StNext;
                end
                StDone: begin
                    pattern_d = '0;
                    state_d   = StIdle;
                end
                default: begin
                    state_d   = StIdle;
                    pattern_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            pattern_q    <= '0;
            fail_vec_q   <= '0;
            fail_count_q <= '0;
            first_fail_q <= 8'hFF;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            pattern_q    <= pattern_d;
            fail_vec_q   <= fail_vec_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign write_enable      = (state_q == StDrive);
    assign busy              = (state_q != StIdle);
    assign done              = (state_q == StDone);
    assign output_pins_state = pattern_q;
    assign fail_vec          = fail_vec_q;
    assign fail_count        = fail_count_q;
    assign first_fail        = first_fail_q;

endmodule

// File: tb/tb_io_pins_walk_test_ctrl.sv
// Self-checking bench for io_pins_walk_test_ctrl with a loopback pin-bank
// model (optionally faulted) and a scoreboard of expected step patterns and
// run results.
module tb_io_pins_walk_test_ctrl;
    import io_pins_pkg::*;

    localparam int unsigned NP = 132;
    localparam int unsigned DC = 2;
    localparam int unsigned SC = 4;
    localparam int unsigned NB = PIN_BYTES * 8;

    localparam int FAULT_NONE   = 0;
    localparam int FAULT_SA0_37 = 1;
    localparam int FAULT_OR_910 = 2;
    localparam int FAULT_SA0_2  = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      abort;
    logic                      mode;
    logic [NP-1:0]             pin_mask;
    logic                      write_enable;
    logic [PIN_BYTES-1:0][7:0] out_st;
    logic [PIN_BYTES-1:0][7:0] in_st;
    logic                      busy;
    logic                      done;
    logic [NP-1:0]             fail_vec;
    logic [7:0]                fail_count;
    logic [7:0]                first_fail;

    io_pins_walk_test_ctrl #(
        .PINS_CONT     (NP),
        .DRIVE_CYCLES  (DC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .CLK50             (clk),
        .RST               (rst),
        .start             (start),
        .abort             (abort),
        .mode              (mode),
        .pin_mask          (pin_mask),
        .write_enable      (write_enable),
        .output_pins_state (out_st),
        .input_pins_state  (in_st),
        .busy              (busy),
        .done              (done),
        .fail_vec          (fail_vec),
        .fail_count        (fail_count),
        .first_fail        (first_fail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin-bank model: latches the driven bytes while write_enable is high,
    // input array reflects them through an optional fault.
    int fault_kind = FAULT_NONE;
    logic [NB-1:0] drv_q;

    function automatic logic [NB-1:0] apply_fault(input logic [NB-1:0] d, input int fk);
        logic [NB-1:0] r;
        logic t;
        r = d;
        case (fk)
            FAULT_SA0_37: r[37] = 1'b0;
            FAULT_OR_910: begin
                t = d[9] | d[10];
                r[9] = t;
                r[10] = t;
            end
            FAULT_SA0_2: r[2] = 1'b0;
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) drv_q <= '0;
        else if (write_enable) drv_q <= out_st;
    end
    assign in_st = apply_fault(drv_q, fault_kind);

    function automatic logic [NB-1:0] exp_pattern(input int idx, input logic md);
        logic [NB-1:0] one;
        logic [NB-1:0] all;
        one = '0;
        one[idx] = 1'b1;
        all = '0;
        for (int i = 0; i < NP; i++) all[i] = 1'b1;
        return md ? (all & ~one) : one;
    endfunction

    typedef struct {
        logic [NP-1:0] fv;
        int            cnt;
        int            first;
        int            lat;
        int            we_cycles;
    } res_t;

    res_t          res_q[$];
    logic [NB-1:0] pat_q[$];

    int   cyc = 0;
    int   start_cyc = 0;
    int   we_cnt = 0;
    int   we_rise = 0;
    bit   done_seen = 0;
    logic we_prev = 1'b0;

    always @(posedge clk) cyc++;

    // Monitor: pops one expected pattern per drive burst and one result per done.
    always @(negedge clk) begin
        logic [NB-1:0] p;
        res_t r;
        if (!rst) begin
            if (write_enable && !we_prev) begin
                we_rise++;
                if (pat_q.size() == 0) begin
                    check_eq("unexpected_drive", 1, 0);
                end else begin
                    p = pat_q.pop_front();
                    check_eq("drive_pattern", out_st, p);
                end
            end
            if (write_enable) we_cnt++;
            if (done) begin
                done_seen = 1;
                if (res_q.size() == 0) begin
                    check_eq("spurious_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check_eq("done_busy", busy, 1);
                    check_eq("fail_vec", fail_vec, r.fv);
                    check_eq("fail_count", fail_count, r.cnt);
                    check_eq("first_fail", first_fail, r.first);
                    check_eq("latency", cyc - start_cyc, r.lat);
                    check_eq("we_cycles", we_cnt, r.we_cycles);
                end
            end
        end
        we_prev = write_enable;
    end

    // Builds the expected step patterns and run result, then pulses start.
    task automatic start_run(input logic md, input logic [NP-1:0] mask, input int fk);
        res_t r;
        logic [NB-1:0] pat;
        logic [NB-1:0] din;
        logic [NB-1:0] cmp;
        int skips;
        int steps;
        r.fv = '0;
        r.cnt = 0;
        r.first = 255;
        skips = 0;
        steps = 0;
        for (int i = 0; i < NP; i++) begin
            if (mask[i]) begin
                skips++;
            end else begin
                steps++;
                pat = exp_pattern(i, md);
                pat_q.push_back(pat);
                din = apply_fault(pat, fk);
                cmp = '0;
                for (int b = 0; b < NP; b++) cmp[b] = !mask[b];
                if (((din ^ pat) & cmp) != '0) begin
                    r.fv[i] = 1'b1;
                    r.cnt++;
                    if (r.first == 255) r.first = i;
                end
            end
        end
        r.lat = 1 + skips + steps * (3 + DC + SC) + 1;
        r.we_cycles = steps * DC;
        res_q.push_back(r);
        @(negedge clk);
        mode = md;
        pin_mask = mask;
        fault_kind = fk;
        start = 1'b1;
        start_cyc = cyc;
        we_cnt = 0;
        done_seen = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (!done_seen) check_eq("done_timeout", 0, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("idle_after_done", {busy, done, write_enable}, 3'b000);
    endtask

    task automatic flush_sb();
        pat_q.delete();
        res_q.delete();
    endtask

    initial begin
        logic [NP-1:0] m;
        int n;
        logic [NP-1:0] fv2;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode = 1'b0;
        pin_mask = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_we", write_enable, 0);
        check_eq("rst_out", out_st, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_fail_vec", fail_vec, 0);
        check_eq("rst_fail_count", fail_count, 0);
        check_eq("rst_first_fail", first_fail, 8'hFF);
        rst = 1'b0;
        @(negedge clk);

        // Clean loopback, walking-one.
        start_run(1'b0, '0, FAULT_NONE);
        wait_done(2000);

        // Pin 37 stuck at 0, walking-one; a start while busy must be ignored.
        start_run(1'b0, '0, FAULT_SA0_37);
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_mid_run", busy, 1);
        wait_done(2000);

        // Same fault, walking-zero.
        start_run(1'b1, '0, FAULT_SA0_37);
        wait_done(2000);

        // Pins 9 and 10 shorted.
        start_run(1'b0, '0, FAULT_OR_910);
        wait_done(2000);

        // Only the top four pins tested.
        m = '0;
        for (int i = 0; i < 128; i++) m[i] = 1'b1;
        start_run(1'b0, m, FAULT_NONE);
        wait_done(500);

        // Abort during step 5 SETTLE, with a failure already recorded at step 2.
        we_rise = 0;
        start_run(1'b0, '0, FAULT_SA0_2);
        n = 0;
        while (we_rise < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_reach_step5", we_rise, 6);
        n = 0;
        while (write_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        flush_sb();
        fv2 = '0;
        fv2[2] = 1'b1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_we", write_enable, 0);
        check_eq("abort_out", out_st, 0);
        check_eq("abort_fail_count", fail_count, 1);
        check_eq("abort_first_fail", first_fail, 2);
        check_eq("abort_fail_vec", fail_vec, fv2);
        // start together with abort in IDLE is dropped.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_busy", busy, 0);
        check_eq("start_abort_hold", fail_count, 1);
        repeat (20) @(negedge clk);
        check_eq("no_done_after_abort", done_seen, 0);

        // Fresh run clears the partial results.
        start_run(1'b0, '0, FAULT_NONE);
        wait_done(2000);

        // Asynchronous reset in the middle of a drive burst.
        we_rise = 0;
        start_run(1'b0, '0, FAULT_SA0_2);
        n = 0;
        while (!(write_enable && we_rise >= 4) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rst_reach_drive", write_enable, 1);
        check_eq("rst_pre_fail_count", fail_count, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_we", write_enable, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_out", out_st, 0);
        check_eq("arst_fail_count", fail_count, 0);
        check_eq("arst_fail_vec", fail_vec, 0);
        check_eq("arst_first_fail", first_fail, 8'hFF);
        flush_sb();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
